// File: rtl/aging_uart_pkg.sv
// Shared types, constants and helpers for the aging-sensor UART framer.
package aging_uart_pkg;

  localparam int unsigned TAG_W     = 4;
  localparam int unsigned NIB_W     = 4;
  localparam int unsigned BYTE_W    = TAG_W + NIB_W;
  localparam int unsigned MAX_BYTES = 15;

  // Tag reserved for the trailing checksum byte
  localparam logic [TAG_W-1:0] TAG_CSUM = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNAP,
    ST_SEND,
    ST_GUARD,
    ST_WAIT
  } state_t;

  // One transmitted byte: sequence tag in the upper nibble, data in the lower
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [NIB_W-1:0] nib;
  } uart_byte_t;

  // Number of nibbles needed to hold w bits
  function automatic int unsigned nib_count(input int unsigned w);
    return (w + NIB_W - 1) / NIB_W;
  endfunction

endpackage

// File: rtl/aging_uart_framer_if.sv
// Byte handshake between the framer and the UART TX core.
interface aging_uart_framer_if;
  import aging_uart_pkg::*;

  logic [BYTE_W-1:0] uart_data_o;
  logic              uart_trans_o;
  logic              uart_busy_i;
  logic              uart_empty_i;

  modport master (
    output uart_data_o,
    output uart_trans_o,
    input  uart_busy_i,
    input  uart_empty_i
  );

  modport slave (
    input  uart_data_o,
    input  uart_trans_o,
    output uart_busy_i,
    output uart_empty_i
  );

endinterface

// File: rtl/aging_nibble_sel.sv
// Combinational nibble picker: returns nibble i of the zero-padded snapshot.
module aging_nibble_sel
  import aging_uart_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DATA_W = 20
) (
  input  logic [NUM_CH*DATA_W-1:0] i_data,
  input  logic [TAG_W-1:0]         i_idx,
  output logic [NIB_W-1:0]         o_nib_c
);

  localparam int unsigned NIB       = nib_count(DATA_W);
  localparam int unsigned PAD_W     = NIB * NIB_W;
  localparam int unsigned NUM_BYTES = NUM_CH * NIB;

  logic [NUM_CH*PAD_W-1:0]              w_padded;
  logic [NIB_W-1:0][NUM_BYTES-1:0]      w_bits;

  // Each channel widened to whole nibbles, upper pad bits forced to zero
  for (genvar c = 0; c < int'(NUM_CH); c++) begin : g_pad
    assign w_padded[c*PAD_W +: PAD_W] = PAD_W'(i_data[c*DATA_W +: DATA_W]);
  end

  // One-hot AND-OR mux per output bit; out-of-range index yields zero
  for (genvar i = 0; i < int'(NUM_BYTES); i++) begin : g_byte
    for (genvar b = 0; b < int'(NIB_W); b++) begin : g_bit
      assign w_bits[b][i] = w_padded[i*NIB_W + b] & (i_idx == TAG_W'(i));
    end
  end

  for (genvar b = 0; b < int'(NIB_W); b++) begin : g_or
    assign o_nib_c[b] = |w_bits[b];
  end

endmodule

// File: rtl/aging_uart_framer.sv
// Aging-sensor result serializer: snapshots NUM_CH words and streams them as
// {tag, nibble} bytes over the UART TX handshake.
// Optional trailing checksum byte enabled by defining AGING_TX_CHECKSUM_EN.
module aging_uart_framer
  import aging_uart_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DATA_W = 20
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     en_i,
  input  logic [NUM_CH*DATA_W-1:0] data_i,
  output logic                     sample_o,
  output logic                     frame_done_o,
  output logic                     busy_o,
  aging_uart_framer_if.master      uart
);

  localparam int unsigned NIB       = nib_count(DATA_W);
  localparam int unsigned NUM_BYTES = NUM_CH * NIB;
`ifdef AGING_TX_CHECKSUM_EN
  localparam int unsigned LAST_IDX  = NUM_BYTES;
`else
  localparam int unsigned LAST_IDX  = NUM_BYTES - 1;
`endif

  // Tags must stay below the reserved checksum tag
  if (NUM_BYTES > MAX_BYTES) begin : g_bad_cfg
    $error("aging_uart_framer: NUM_CH*NIB exceeds 15");
  end

  state_t                  r_state, w_state_nxt;
  logic [NUM_CH*DATA_W-1:0] r_snap, w_snap_nxt, w_sel_src;
  logic [TAG_W-1:0]        r_idx, w_idx_nxt, w_idx_inc, w_sel_idx;
  uart_byte_t              r_data, w_data_nxt;
  logic                    r_trans, w_trans_nxt;
  logic                    r_sample, w_sample_nxt;
  logic                    r_done, w_done_nxt;
  logic                    r_busy, w_busy_nxt;
  logic [NIB_W-1:0]        w_nib;
`ifdef AGING_TX_CHECKSUM_EN
  logic [NIB_W-1:0]        r_acc, w_acc_nxt;
`endif

  // First byte is picked straight from data_i since the snapshot loads on the same edge
  assign w_idx_inc = r_idx + TAG_W'(1);
  assign w_sel_src = (r_state == ST_SNAP) ? data_i : r_snap;
  assign w_sel_idx = (r_state == ST_SNAP) ? '0 : w_idx_inc;

  aging_nibble_sel #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W)
  ) u_nibble_sel (
    .i_data  (w_sel_src),
    .i_idx   (w_sel_idx),
    .o_nib_c (w_nib)
  );

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_snap   <= '0;
      r_idx    <= '0;
      r_data   <= '0;
      r_trans  <= 1'b0;
      r_sample <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
`ifdef AGING_TX_CHECKSUM_EN
      r_acc    <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_snap   <= w_snap_nxt;
      r_idx    <= w_idx_nxt;
      r_data   <= w_data_nxt;
      r_trans  <= w_trans_nxt;
      r_sample <= w_sample_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= w_busy_nxt;
`ifdef AGING_TX_CHECKSUM_EN
      r_acc    <= w_acc_nxt;
`endif
    end
  end

  // Next state and next registered outputs
  always_comb begin
    w_state_nxt  = r_state;
    w_snap_nxt   = r_snap;
    w_idx_nxt    = r_idx;
    w_data_nxt   = r_data;
    w_trans_nxt  = 1'b0;
    w_sample_nxt = 1'b0;
    w_done_nxt   = 1'b0;
`ifdef AGING_TX_CHECKSUM_EN
    w_acc_nxt    = r_acc;
`endif
    case (r_state)
      ST_IDLE: begin
        if (en_i && uart.uart_empty_i) begin
          w_state_nxt  = ST_SNAP;
          w_sample_nxt = 1'b1;
        end
      end
      ST_SNAP: begin
        w_snap_nxt  = data_i;
        w_idx_nxt   = '0;
        w_data_nxt  = '{tag: '0, nib: w_nib};
        w_trans_nxt = 1'b1;
        w_state_nxt = ST_SEND;
`ifdef AGING_TX_CHECKSUM_EN
        w_acc_nxt   = w_nib;
`endif
      end
      ST_SEND:  w_state_nxt = ST_GUARD;
      ST_GUARD: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (!uart.uart_busy_i) begin
          if (r_idx == TAG_W'(LAST_IDX)) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_idx_nxt   = w_idx_inc;
            w_trans_nxt = 1'b1;
            w_state_nxt = ST_SEND;
            w_data_nxt  = '{tag: w_idx_inc, nib: w_nib};
`ifdef AGING_TX_CHECKSUM_EN
            if (w_idx_inc == TAG_W'(NUM_BYTES)) begin
              w_data_nxt = '{tag: TAG_CSUM, nib: r_acc};
            end else begin
              w_acc_nxt = r_acc ^ w_nib;
            end
`endif
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  assign uart.uart_data_o  = r_data;
  assign uart.uart_trans_o = r_trans;
  assign sample_o          = r_sample;
  assign frame_done_o      = r_done;
  assign busy_o            = r_busy;

endmodule

// File: doc/aging_uart_framer.md
# aging_uart_framer

Parametrised serializer for aging-sensor results. It snapshots NUM_CH sensor words of DATA_W bits and streams them to the UART transmitter as tagged nibble bytes, one byte per UART handshake. Each byte carries a 4-bit sequence tag in the upper nibble and 4 data bits in the lower nibble. It sits between the aging-sensor counter outputs and the UART TX core, and adds an input snapshot, an enable/continuous mode, frame-done signalling and an optional checksum byte.

## Interface
- NUM_CH, default 2: number of sensor channels.
- DATA_W, default 20: bits per channel.
- NIB (derived, not overridable): ceil(DATA_W/4), nibbles per channel.
- Elaboration rule: NUM_CH*NIB ≤ 15; otherwise elaboration fails.
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- en_i  in  1  frame start enable; frames repeat while high.
- data_i  in  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W].
- sample_o  out  1  one-cycle pulse when data_i is captured.
- frame_done_o  out  1  one-cycle pulse after the last byte of a frame is accepted.
- busy_o  out  1  high whenever state ≠ IDLE.
- uart_data_o  out  8  byte to transmit: {tag[3:0], nibble[3:0]}.
- uart_trans_o  out  1  one-cycle transmit strobe.
- uart_busy_i  in  1  UART TX is shifting.
- uart_empty_i  in  1  UART TX FIFO/buffer is empty.

## Operation
- States: IDLE, SNAP, SEND, GUARD, WAIT.
- IDLE → SNAP when en_i && uart_empty_i. Otherwise remain in IDLE.
- SNAP:
  - Register all of data_i into the snapshot.
  - Clear the byte index to 0 and the checksum accumulator to 0.
  - Assert sample_o.
  - Go to SEND.
- SEND:
  - Assert uart_trans_o with the byte for the current index.
  - XOR the byte's nibble into the accumulator.
  - Go to GUARD.
- GUARD: one cycle in which uart_busy_i is ignored, to cover strobe-to-busy latency. Go to WAIT.
- WAIT: when ~uart_busy_i:
  - If this was not the last byte: increment the index and go to SEND.
  - If this was the last byte: go to IDLE and pulse frame_done_o.
- Byte order:
  - Index i = c*NIB + n, where c is the channel (0 first) and n is the nibble (LSB nibble first).
  - Tag = i[3:0]. Nibble = snapshot bits [c*DATA_W + 4n +: 4].
  - Bits above DATA_W in the top nibble are sent as 0.
- The frame always uses the snapshot. data_i changes after SNAP do not affect the frame in flight.
- en_i falling mid-frame: the current frame completes, then the block stays in IDLE.
- en_i held high: back-to-back frames. A new SNAP occurs on the first IDLE cycle with uart_empty_i high, which may be the same cycle as frame_done_o.
- Reset, asynchronous, at any time:
  - State → IDLE.
  - All outputs → 0, including uart_data_o = 8'h00.
  - Snapshot, index and accumulator → 0.
  - A partial frame is abandoned and never resumed.

## Timing
- All outputs come from registers. There is no combinational path from inputs to outputs.
- en_i && uart_empty_i sampled at cycle t:
  - sample_o at t+1.
  - First uart_trans_o at t+2.
- Each byte takes at least 3 cycles (SEND, GUARD, WAIT). WAIT extends while uart_busy_i is high.
- Default parameters, uart_busy_i held low:
  - uart_trans_o at t+2, t+5, …, t+29.
  - frame_done_o at t+32.
- uart_data_o holds its value from SEND until the next SEND.
- uart_trans_o is never high on two consecutive cycles.

## Configuration
- AGING_TX_CHECKSUM_EN defined:
  - After the last data byte, one extra byte {4'hF, XOR of all transmitted data nibbles} is sent with the same SEND/GUARD/WAIT handshake.
  - frame_done_o follows acceptance of the checksum byte.
  - Tag 4'hF is reserved for the checksum.
  - Default frame is 11 bytes; frame_done_o at t+35.
- AGING_TX_CHECKSUM_EN undefined:
  - The frame ends after the data bytes; there is no checksum logic.
  - Tag 4'hF is unused.

## Structure
- Package aging_uart_pkg:
  - State enum.
  - TAG_CSUM = 4'hF.
  - Nibble-count function ceil(w/4).
  - Byte-format field widths.
- Sub-module aging_nibble_sel: combinational selection of the snapshot nibble by index, with zero-padding of bits above DATA_W.
- FSM, index counter and accumulator live in the top module.

## Test plan
- Default parameters, ch0 = 20'hABCDE, ch1 = 20'h12345, busy low, en_i pulsed for one cycle → bytes 0x0E,0x1D,0x2C,0x3B,0x4A,0x55,0x64,0x73,0x82,0x91, then frame_done_o at t+32. With AGING_TX_CHECKSUM_EN, byte 0xFF follows the data bytes.
- uart_busy_i high for 10 cycles after each strobe → each following strobe only after busy falls. The next byte is never strobed during GUARD.
- data_i changed to all-ones one cycle after sample_o → the transmitted frame still carries the snapshot values.
- en_i held high, uart_empty_i low for 5 cycles after the first frame → second sample_o only once uart_empty_i rises. No strobe while waiting.
- rstn asserted after the 4th byte → all outputs 0 immediately. After release with en_i high, a new frame starts at tag 0.
- DATA_W = 6, NUM_CH = 3, ch0 = 6'h3F → bytes 0x0F, 0x13 (padding zero). Tags run 0..5.
